// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetches, queues in-order responses with their PCs and
// discards stale responses after a redirect. Defining IFB_BYPASS_EN forwards a response to an empty buffer's output.
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] total_q, total_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [31:0]   pc4_q  [DEPTH];
  logic [31:0]   pc4_d  [DEPTH];

  logic [CW-1:0] live;
  logic [CW:0]   budget;
  logic          fifo_empty, req_fire, rsp_live, bypass_hit, push, pop;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a request, once raised, holds valid and address until accepted unless a redirect drops it.
  always_comb begin
    live          = total_q - drop_q;
    budget        = {1'b0, live} + {1'b0, count_q};
    fifo_empty    = (count_q == '0);
    mem_req_valid = !reset && !redirect && (budget < {1'b0, DEPTH_C}) && (total_q < DEPTH_C);
    mem_req_addr  = fetch_pc_q;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_live      = !reset && mem_rsp_valid && !redirect && (state_q == RUN);
`ifdef IFB_BYPASS_EN
    bypass_hit    = rsp_live && fifo_empty;
`else
    bypass_hit    = 1'b0;
`endif
    pop           = !reset && !redirect && !fifo_empty && instr_ready;
    push          = rsp_live && !(bypass_hit && instr_ready);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    total_d    = total_q + CW'(req_fire) - CW'(mem_rsp_valid);
    if (redirect) begin
      // Everything still in flight belongs to the old path, except a response arriving right now.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_d     = total_q - CW'(mem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (mem_rsp_valid && (state_q == DRAIN)) drop_d = drop_q - CW'(1);
      if (rsp_live) rsp_pc_d = rsp_pc_q + 32'd4;
      if (push) begin
        data_d[wr_ptr_q] = mem_rsp_data;
        pc_d[wr_ptr_q]   = rsp_pc_q;
        pc4_d[wr_ptr_q]  = rsp_pc_q + 32'd4;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_comb begin
    instr_valid    = !fifo_empty || bypass_hit;
    instr          = data_q[rd_ptr_q];
    instr_pc       = pc_q[rd_ptr_q];
    instr_pc_plus4 = pc4_q[rd_ptr_q];
    if (bypass_hit) begin
      instr          = mem_rsp_data;
      instr_pc       = rsp_pc_q;
      instr_pc_plus4 = rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      total_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
        pc4_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      total_q    <= total_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
    end
  end

  // The request throttle guarantees a live response always finds a free slot.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_live && (count_q == DEPTH_C)))
        else $error("instr_fetch_buffer: live response arrived with the buffer full");
    end
  end
endmodule
